id_ex_stage_reg: RTL and testbench

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

---
 rtl/id_ex_stage_reg.sv | 117 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, hold/flush control
// and a saturating count of inserted load-use bubbles.
module id_ex_stage_reg #(
   parameter logic [4:0] XZR = 5'd31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  Rn_d,
   input  logic [4:0]  Rm_d,
   input  logic [4:0]  Rd_d,
   input  logic [63:0] Da_d,
   input  logic [63:0] Db_d,
   input  logic [63:0] imm_d,
   input  logic        RegWrite_d,
   input  logic        MemWrite_d,
   input  logic        MemRead_d,
   input  logic [2:0]  ALUSrc_d,
   input  logic [2:0]  ALUOp_d,
   input  logic        hold,
   input  logic        flush,
   output logic [4:0]  Rn_e,
   output logic [4:0]  Rm_e,
   output logic [4:0]  Rd_e,
   output logic [63:0] Da_e,
   output logic [63:0] Db_e,
   output logic [63:0] imm_e,
   output logic        RegWrite_e,
   output logic        MemWrite_e,
   output logic        MemRead_e,
   output logic        valid_e,
   output logic [2:0]  ALUSrc_e,
   output logic [2:0]  ALUOp_e,
   output logic        stall,
   output logic [15:0] bubble_cnt
);

   typedef struct packed {
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [4:0]  rd;
      logic [63:0] da;
      logic [63:0] db;
      logic [63:0] imm;
      logic        reg_write;
      logic        mem_write;
      logic        mem_read;
      logic        valid;
      logic [2:0]  alu_src;
      logic [2:0]  alu_op;
   } ex_t;

   ex_t         ex_d, ex_q, bubble;
   logic [15:0] bubble_cnt_d, bubble_cnt_q;
   logic        hazard;

   always_comb begin
      bubble    = '0;
      bubble.rd = XZR;
   end

   // A load writing XZR produces nothing a consumer could depend on.
   assign hazard = ex_q.mem_read & ex_q.reg_write & ex_q.valid & (ex_q.rd != XZR) &
                   ((ex_q.rd == Rn_d) | (ex_q.rd == Rm_d));
   assign stall  = hazard | hold;

   always_comb begin
      ex_d         = ex_q;
      bubble_cnt_d = bubble_cnt_q;
      if (!hold) begin
         if (flush) begin
            ex_d = bubble;
         end else if (hazard) begin
            ex_d = bubble;
            if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
         end else begin
            ex_d.rn        = Rn_d;
            ex_d.rm        = Rm_d;
            ex_d.rd        = Rd_d;
            ex_d.da        = Da_d;
            ex_d.db        = Db_d;
            ex_d.imm       = imm_d;
            ex_d.reg_write = RegWrite_d;
            ex_d.mem_write = MemWrite_d;
            ex_d.mem_read  = MemRead_d;
            ex_d.valid     = 1'b1;
            ex_d.alu_src   = ALUSrc_d;
            ex_d.alu_op    = ALUOp_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q         <= '0;
         ex_q.rd      <= XZR;
         bubble_cnt_q <= 16'd0;
      end else begin
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign Rn_e       = ex_q.rn;
   assign Rm_e       = ex_q.rm;
   assign Rd_e       = ex_q.rd;
   assign Da_e       = ex_q.da;
   assign Db_e       = ex_q.db;
   assign imm_e      = ex_q.imm;
   assign RegWrite_e = ex_q.reg_write;
   assign MemWrite_e = ex_q.mem_write;
   assign MemRead_e  = ex_q.mem_read;
   assign valid_e    = ex_q.valid;
   assign ALUSrc_e   = ex_q.alu_src;
   assign ALUOp_e    = ex_q.alu_op;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus randomized traffic
// checked against a transaction-level model of the E stage.
module tb_id_ex_stage_reg;

   typedef struct packed {
      logic [4:0]  rn, rm, rd;
      logic [63:0] da, db, imm;
      logic        rw, mw, mr, valid;
      logic [2:0]  as, ao;
   } stg_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  Rn_d, Rm_d, Rd_d;
   logic [63:0] Da_d, Db_d, imm_d;
   logic        RegWrite_d, MemWrite_d, MemRead_d;
   logic [2:0]  ALUSrc_d, ALUOp_d;
   logic        hold, flush;
   logic [4:0]  Rn_e, Rm_e, Rd_e;
   logic [63:0] Da_e, Db_e, imm_e;
   logic        RegWrite_e, MemWrite_e, MemRead_e, valid_e;
   logic [2:0]  ALUSrc_e, ALUOp_e;
   logic        stall;
   logic [15:0] bubble_cnt;

   int   n_chk = 0;
   int   n_fail = 0;
   stg_t exp_e;
   int   exp_cnt;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk(clk), .rst_n(rst_n),
      .Rn_d(Rn_d), .Rm_d(Rm_d), .Rd_d(Rd_d),
      .Da_d(Da_d), .Db_d(Db_d), .imm_d(imm_d),
      .RegWrite_d(RegWrite_d), .MemWrite_d(MemWrite_d), .MemRead_d(MemRead_d),
      .ALUSrc_d(ALUSrc_d), .ALUOp_d(ALUOp_d),
      .hold(hold), .flush(flush),
      .Rn_e(Rn_e), .Rm_e(Rm_e), .Rd_e(Rd_e),
      .Da_e(Da_e), .Db_e(Db_e), .imm_e(imm_e),
      .RegWrite_e(RegWrite_e), .MemWrite_e(MemWrite_e), .MemRead_e(MemRead_e),
      .valid_e(valid_e), .ALUSrc_e(ALUSrc_e), .ALUOp_e(ALUOp_e),
      .stall(stall), .bubble_cnt(bubble_cnt)
   );

   function automatic stg_t bub();
      stg_t b = '0;
      b.rd = 5'd31;
      return b;
   endfunction

   function automatic stg_t act();
      return '{rn: Rn_e, rm: Rm_e, rd: Rd_e, da: Da_e, db: Db_e, imm: imm_e,
               rw: RegWrite_e, mw: MemWrite_e, mr: MemRead_e, valid: valid_e,
               as: ALUSrc_e, ao: ALUOp_e};
   endfunction

   // Reference: a consumer in D reads the destination of a still-pending load.
   function automatic bit model_hazard();
      return exp_e.valid && exp_e.mr && exp_e.rw && exp_e.rd != 5'd31 &&
             (exp_e.rd == Rn_d || exp_e.rd == Rm_d);
   endfunction

   task automatic set_d(input logic [4:0] rn, rm, rd, input logic [63:0] da,
                        input logic rw, mw, mr);
      Rn_d = rn; Rm_d = rm; Rd_d = rd; Da_d = da;
      Db_d = da ^ 64'hA5A5_0000_FFFF_1234; imm_d = {59'd0, rd} + 64'd100;
      RegWrite_d = rw; MemWrite_d = mw; MemRead_d = mr;
      ALUSrc_d = {2'b00, mr}; ALUOp_d = 3'd2;
   endtask

   task automatic rand_d();
      Rn_d = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      Rm_d = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      Rd_d = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      Da_d = {$urandom, $urandom}; Db_d = {$urandom, $urandom}; imm_d = {$urandom, $urandom};
      MemRead_d = ($urandom_range(0, 9) < 4);
      RegWrite_d = MemRead_d ? ($urandom_range(0, 9) != 0) : 1'($urandom);
      MemWrite_d = 1'($urandom);
      ALUSrc_d = 3'($urandom); ALUOp_d = 3'($urandom);
   endtask

   // Advance one edge, updating the model from the inputs seen at that edge.
   task automatic tick();
      stg_t nxt = exp_e;
      int   ncnt = exp_cnt;
      if (hold) nxt = exp_e;
      else if (flush) nxt = bub();
      else if (model_hazard()) begin
         nxt = bub();
         ncnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
      end else
         nxt = '{rn: Rn_d, rm: Rm_d, rd: Rd_d, da: Da_d, db: Db_d, imm: imm_d,
                 rw: RegWrite_d, mw: MemWrite_d, mr: MemRead_d, valid: 1'b1,
                 as: ALUSrc_d, ao: ALUOp_d};
      @(posedge clk);
      #1;
      exp_e = nxt;
      exp_cnt = ncnt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
      set_d(5'd1, 5'd2, 5'd3, 64'h77, 1'b1, 1'b0, 1'b0);
      exp_e = bub(); exp_cnt = 0;
      #7;
      n_chk++; if (act() !== bub()) begin n_fail++; $display("FAIL reset_state got %h want %h", act(), bub()); end
      n_chk++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bubble_cnt); end
      #10;
      n_chk++; if (act() !== bub()) begin n_fail++; $display("FAIL reset_held got %h want %h", act(), bub()); end
      rst_n = 1'b1;
      tick();
      n_chk++; if (valid_e !== 1'b1 || Rd_e !== 5'd3) begin n_fail++; $display("FAIL first_load got valid=%b rd=%0d want 1/3", valid_e, Rd_e); end
   endtask

   task automatic test_pass_through();
      set_d(5'd1, 5'd2, 5'd3, 64'h5, 1'b1, 1'b0, 1'b0);
      tick();
      n_chk++; if (Rd_e !== 5'd3 || Da_e !== 64'h5 || valid_e !== 1'b1) begin n_fail++; $display("FAIL pass_through got rd=%0d da=%h v=%b want 3/5/1", Rd_e, Da_e, valid_e); end
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pass_stall got %b want 0", stall); end
      n_chk++; if (act() !== exp_e) begin n_fail++; $display("FAIL pass_fields got %h want %h", act(), exp_e); end
   endtask

   task automatic test_load_use();
      int c0;
      set_d(5'd0, 5'd0, 5'd4, 64'h40, 1'b1, 1'b0, 1'b1);
      tick();
      set_d(5'd4, 5'd5, 5'd6, 64'h66, 1'b1, 1'b0, 1'b0);
      #1;
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall); end
      c0 = exp_cnt;
      tick();
      n_chk++; if (valid_e !== 1'b0 || Rd_e !== 5'd31 || MemRead_e !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got v=%b rd=%0d mr=%b want 0/31/0", valid_e, Rd_e, MemRead_e); end
      n_chk++; if (int'(bubble_cnt) !== c0 + 1) begin n_fail++; $display("FAIL lu_cnt got %0d want %0d", bubble_cnt, c0 + 1); end
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_no_second got %b want 0", stall); end
      tick();
      n_chk++; if (Rd_e !== 5'd6 || valid_e !== 1'b1 || Rn_e !== 5'd4) begin n_fail++; $display("FAIL lu_dep_load got rd=%0d v=%b want 6/1", Rd_e, valid_e); end
   endtask

   task automatic test_load_xzr();
      int c0 = exp_cnt;
      set_d(5'd1, 5'd2, 5'd31, 64'h31, 1'b1, 1'b0, 1'b1);
      tick();
      set_d(5'd31, 5'd31, 5'd9, 64'h99, 1'b1, 1'b0, 1'b0);
      #1;
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL xzr_stall got %b want 0", stall); end
      tick();
      n_chk++; if (Rd_e !== 5'd9 || valid_e !== 1'b1 || int'(bubble_cnt) !== c0) begin n_fail++; $display("FAIL xzr_load got rd=%0d v=%b cnt=%0d want 9/1/%0d", Rd_e, valid_e, bubble_cnt, c0); end
   endtask

   task automatic test_flush_hazard();
      int c0 = exp_cnt;
      set_d(5'd0, 5'd1, 5'd7, 64'h70, 1'b1, 1'b0, 1'b1);
      tick();
      set_d(5'd7, 5'd0, 5'd8, 64'h80, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      #1;
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fh_stall got %b want 1", stall); end
      tick();
      flush = 1'b0;
      n_chk++; if (act() !== bub() || int'(bubble_cnt) !== c0) begin n_fail++; $display("FAIL fh_bubble got %h cnt=%0d want %h cnt=%0d", act(), bubble_cnt, bub(), c0); end
   endtask

   task automatic test_hold();
      stg_t saved;
      set_d(5'd2, 5'd3, 5'd5, 64'h1234, 1'b1, 1'b1, 1'b0);
      tick();
      saved = exp_e;
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_d();
         #1;
         n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d] got %b want 1", i, stall); end
         tick();
         n_chk++; if (act() !== saved) begin n_fail++; $display("FAIL hold_keep[%0d] got %h want %h", i, act(), saved); end
      end
      hold = 1'b0;
      set_d(5'd6, 5'd6, 5'd10, 64'hBEEF, 1'b0, 1'b0, 1'b0);
      tick();
      n_chk++; if (Rd_e !== 5'd10 || Da_e !== 64'hBEEF || valid_e !== 1'b1) begin n_fail++; $display("FAIL hold_release got rd=%0d da=%h want 10/beef", Rd_e, Da_e); end
   endtask

   task automatic test_async_reset();
      int guard = 0;
      while (exp_cnt < 7 && guard < 40) begin
         set_d(5'd0, 5'd0, 5'd4, 64'h4, 1'b1, 1'b0, 1'b1);
         tick();
         set_d(5'd4, 5'd1, 5'd2, 64'h2, 1'b1, 1'b0, 1'b0);
         tick();
         guard++;
      end
      set_d(5'd1, 5'd1, 5'd12, 64'hC, 1'b1, 1'b0, 1'b0);
      tick();
      n_chk++; if (valid_e !== 1'b1 || bubble_cnt !== 16'd7) begin n_fail++; $display("FAIL ar_pre got v=%b cnt=%0d want 1/7", valid_e, bubble_cnt); end
      #2 rst_n = 1'b0;
      exp_e = bub(); exp_cnt = 0;
      #1;
      n_chk++; if (valid_e !== 1'b0 || Rd_e !== 5'd31 || bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_async got v=%b rd=%0d cnt=%0d want 0/31/0", valid_e, Rd_e, bubble_cnt); end
      @(posedge clk); #3;
      n_chk++; if (act() !== bub()) begin n_fail++; $display("FAIL ar_held got %h want %h", act(), bub()); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_saturation();
      force dut.bubble_cnt_q = 16'hFFFC;
      #1 release dut.bubble_cnt_q;
      exp_cnt = 16'hFFFC;
      for (int i = 0; i < 5; i++) begin
         set_d(5'd0, 5'd0, 5'd3, 64'h3, 1'b1, 1'b0, 1'b1);
         tick();
         set_d(5'd3, 5'd0, 5'd1, 64'h1, 1'b1, 1'b0, 1'b0);
         tick();
         n_chk++; if (int'(bubble_cnt) !== exp_cnt) begin n_fail++; $display("FAIL sat[%0d] got %h want %h", i, bubble_cnt, exp_cnt[15:0]); end
      end
      n_chk++; if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got %h want ffff", bubble_cnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rand_d();
         hold  = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 9) == 0);
         #1;
         n_chk++; if (stall !== (model_hazard() | hold)) begin n_fail++; $display("FAIL rnd_stall[%0d] got %b want %b", i, stall, model_hazard() | hold); end
         tick();
         n_chk++; if (act() !== exp_e || int'(bubble_cnt) !== exp_cnt) begin n_fail++; $display("FAIL rnd_state[%0d] got %h/%0d want %h/%0d", i, act(), bubble_cnt, exp_e, exp_cnt); end
      end
      hold = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load_use();
      test_load_xzr();
      test_flush_hazard();
      test_hold();
      test_async_reset();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
